// File: rtl/sitcpxg_rx_drain.sv
// Receive-buffer drain for the SiTCP 10GbE core: owns the RX RAM, tracks the write end and
// replays received bytes as a left-justified 64-bit valid/ready stream.
module sitcpxg_rx_drain #(
  parameter int unsigned ADR_W = 16
) (
  input  logic        XGMII_CLOCK,
  input  logic        RSTn,
  input  logic [15:0] RX_WADR,
  input  logic [7:0]  RX_WENB,
  input  logic [63:0] RX_WDAT,
  input  logic        RX_CLR_ENB,
  output logic        RX_CLR_REQ,
  output logic [15:0] RX_SIZE,
  output logic [15:0] RX_RADR,
  output logic [63:0] OUT_D,
  output logic [3:0]  OUT_B,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);

  localparam int unsigned WordW = ADR_W - 3;
  localparam int unsigned Words = 1 << WordW;
  localparam logic [15:0] RxSize = 16'((32'd1 << ADR_W) - 32'd16);

  typedef logic [ADR_W-1:0] ptr_t;
  typedef enum logic [1:0] {StIdle, StReq, StDone} clr_st_e;

  clr_st_e st_q;
  logic    clr_req_q;

  ptr_t wr_end_q, wr_end_d;
  ptr_t iss_ptr_q, iss_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;

  logic [63:0] mem_q [Words];
  logic [63:0] rd_data_q;
  logic        rd_vld_q;
  logic [2:0]  rd_off_q;
  logic [3:0]  rd_n_q;

  logic [63:0] f0_dat_q, f0_dat_d, f1_dat_q, f1_dat_d;
  logic [3:0]  f0_len_q, f0_len_d, f1_len_q, f1_len_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [WordW-1:0] wr_word;
  logic [2:0]       low_k;
  logic [3:0]       wr_len;
  ptr_t             wr_end_new;
  logic             wr_any;
  ptr_t             avail, pending;
  logic [2:0]       iss_off;
  logic [3:0]       room, iss_n;
  logic [1:0]       occ;
  logic             issue, push, pop, clr_go;
  logic [63:0]      shifted, ret_dat;
  logic             unused_wadr;

  assign unused_wadr = ^RX_WADR;
  assign wr_word     = RX_WADR[ADR_W-1:3];
  assign wr_any      = (RX_WENB != 8'h00);

  // Lowest set enable marks the last byte written (big-endian lanes).
  always_comb begin
    low_k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (RX_WENB[i]) low_k = 3'(i);
    end
  end

  assign wr_len     = 4'd8 - {1'b0, low_k};
  assign wr_end_new = {wr_word, 3'b000} + ptr_t'(wr_len);

  assign avail   = wr_end_q - iss_ptr_q;
  assign pending = wr_end_q - rd_ptr_q;
  assign iss_off = iss_ptr_q[2:0];
  assign room    = 4'd8 - {1'b0, iss_off};
  assign iss_n   = (avail < ptr_t'(room)) ? avail[3:0] : room;

  assign pop  = OUT_VALID & OUT_READY;
  assign push = rd_vld_q;
  // Credit this cycle's pop so a full-rate stream is not throttled to every other cycle.
  assign occ   = {1'b0, rd_vld_q} + cnt_q - {1'b0, pop};
  assign issue = (avail != '0) && (occ < 2'd2) && (st_q != StReq);

  assign clr_go = RX_CLR_ENB && (pending == '0) && !rd_vld_q && (cnt_q == 2'd0) && !wr_any;

  always_ff @(posedge XGMII_CLOCK) begin
    for (int i = 0; i < 8; i++) begin
      if (RX_WENB[i]) mem_q[wr_word][8*i +: 8] <= RX_WDAT[8*i +: 8];
    end
    if (issue) rd_data_q <= mem_q[iss_ptr_q[ADR_W-1:3]];
  end

  assign shifted = rd_data_q << {rd_off_q, 3'b000};

  always_comb begin
    ret_dat = '0;
    for (int j = 0; j < 8; j++) begin
      ret_dat[63-8*j -: 8] = (4'(j) < rd_n_q) ? shifted[63-8*j -: 8] : 8'h00;
    end
  end

  // A write landing in the request cycle is applied on top of the pointer reset.
  always_comb begin
    wr_end_d = wr_end_q;
    if (st_q == StReq) wr_end_d = '0;
    if (wr_any) wr_end_d = wr_end_new;

    iss_ptr_d = iss_ptr_q;
    if (st_q == StReq) begin
      iss_ptr_d = '0;
    end else if (issue) begin
      iss_ptr_d = iss_ptr_q + ptr_t'(iss_n);
    end

    rd_ptr_d = rd_ptr_q;
    if (st_q == StReq) begin
      rd_ptr_d = '0;
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(OUT_B);
    end
  end

  // Entry 1 is kept zero whenever it is empty, so shifting it forward clears entry 0.
  always_comb begin
    f0_dat_d = f0_dat_q;
    f0_len_d = f0_len_q;
    f1_dat_d = f1_dat_q;
    f1_len_d = f1_len_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10: begin
        if (cnt_q == 2'd0) begin
          f0_dat_d = ret_dat;
          f0_len_d = rd_n_q;
        end else begin
          f1_dat_d = ret_dat;
          f1_len_d = rd_n_q;
        end
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        f0_dat_d = f1_dat_q;
        f0_len_d = f1_len_q;
        f1_dat_d = '0;
        f1_len_d = '0;
        cnt_d    = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          f0_dat_d = ret_dat;
          f0_len_d = rd_n_q;
        end else begin
          f0_dat_d = f1_dat_q;
          f0_len_d = f1_len_q;
          f1_dat_d = ret_dat;
          f1_len_d = rd_n_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      wr_end_q  <= '0;
      iss_ptr_q <= '0;
      rd_ptr_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_off_q  <= '0;
      rd_n_q    <= '0;
      f0_dat_q  <= '0;
      f0_len_q  <= '0;
      f1_dat_q  <= '0;
      f1_len_q  <= '0;
      cnt_q     <= '0;
    end else begin
      wr_end_q  <= wr_end_d;
      iss_ptr_q <= iss_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_vld_q  <= issue;
      if (issue) begin
        rd_off_q <= iss_off;
        rd_n_q   <= iss_n;
      end
      f0_dat_q <= f0_dat_d;
      f0_len_q <= f0_len_d;
      f1_dat_q <= f1_dat_d;
      f1_len_q <= f1_len_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      st_q      <= StIdle;
      clr_req_q <= 1'b0;
    end else begin
      clr_req_q <= 1'b0;
      unique case (st_q)
        StIdle: begin
          if (clr_go) begin
            st_q      <= StReq;
            clr_req_q <= 1'b1;
          end
        end
        StReq:  st_q <= StDone;
        StDone: if (!RX_CLR_ENB) st_q <= StIdle;
        default: st_q <= StIdle;
      endcase
    end
  end

  assign RX_CLR_REQ = clr_req_q;
  assign RX_SIZE    = RxSize;
  assign RX_RADR    = 16'(rd_ptr_q);
  assign OUT_D      = f0_dat_q;
  assign OUT_B      = f0_len_q;
  assign OUT_VALID  = (cnt_q != 2'd0);

endmodule

// File: tb/tb_sitcpxg_rx_drain.sv
// Directed bench for sitcpxg_rx_drain at ADR_W = 12 (small enough to exercise the wrap).
module tb_sitcpxg_rx_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] wadr = '0;
  logic [7:0]  wenb = '0;
  logic [63:0] wdat = '0;
  logic        clr_enb = 1'b0;
  logic        clr_req;
  logic [15:0] rx_size, rx_radr;
  logic [63:0] out_d;
  logic [3:0]  out_b;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int accepted, bad, gaps, pulses;

  sitcpxg_rx_drain #(.ADR_W(12)) dut (
    .XGMII_CLOCK(clk),
    .RSTn       (rst_n),
    .RX_WADR    (wadr),
    .RX_WENB    (wenb),
    .RX_WDAT    (wdat),
    .RX_CLR_ENB (clr_enb),
    .RX_CLR_REQ (clr_req),
    .RX_SIZE    (rx_size),
    .RX_RADR    (rx_radr),
    .OUT_D      (out_d),
    .OUT_B      (out_b),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [15:0] adr, input logic [7:0] en, input logic [63:0] dat);
    wadr = adr;
    wenb = en;
    wdat = dat;
    @(negedge clk);
    wenb = 8'h00;
  endtask

  // Called right after wr() on an empty pipeline: word must appear exactly 3 cycles on.
  task automatic expect_word(input string tag, input logic [63:0] d, input logic [3:0] b);
    check_eq({tag, "_v1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq({tag, "_v2"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check_eq({tag, "_v3"}, 64'(out_valid), 64'd1);
    check_eq({tag, "_d"}, out_d, d);
    check_eq({tag, "_b"}, 64'(out_b), 64'(b));
  endtask

  task automatic sample_bulk();
    if (out_valid && out_ready) begin
      if (out_d !== (64'hC0DE_0000_0000_0000 | 64'(32'h38 + 32'(accepted) * 8))) bad++;
      accepted++;
    end else if (accepted > 0 && accepted < 504) begin
      gaps++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_d", out_d, 64'd0);
    check_eq("rst_b", 64'(out_b), 64'd0);
    check_eq("rst_radr", 64'(rx_radr), 64'd0);
    check_eq("rst_clrreq", 64'(clr_req), 64'd0);
    check_eq("rx_size", 64'(rx_size), 64'h0FF0);
    rst_n = 1'b1;
    @(negedge clk);

    // Aligned words
    wr(16'h000, 8'hFF, 64'h0102_0304_0506_0708);
    expect_word("al0", 64'h0102_0304_0506_0708, 4'd8);
    @(negedge clk);
    check_eq("al0_radr", 64'(rx_radr), 64'h008);
    check_eq("al0_empty", 64'(out_valid), 64'd0);
    wr(16'h008, 8'hFF, 64'hA0A1_A2A3_A4A5_A6A7);
    expect_word("al1", 64'hA0A1_A2A3_A4A5_A6A7, 4'd8);
    @(negedge clk);
    check_eq("al1_radr", 64'(rx_radr), 64'h010);

    // Word written in two halves
    wr(16'h010, 8'hF0, 64'h1122_3344_5566_7788);
    expect_word("sp0", 64'h1122_3344_0000_0000, 4'd4);
    @(negedge clk);
    check_eq("sp0_radr", 64'(rx_radr), 64'h014);
    wr(16'h010, 8'h0F, 64'h1122_3344_5566_7788);
    expect_word("sp1", 64'h5566_7788_0000_0000, 4'd4);
    @(negedge clk);
    check_eq("sp1_radr", 64'(rx_radr), 64'h018);

    // Backpressure: four words stalled for 10 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(16'(16'h018 + 8 * i), 8'hFF, 64'hB000_0000_0000_0000 + 64'(i));
    repeat (6) @(negedge clk);
    check_eq("bp_hold_v", 64'(out_valid), 64'd1);
    check_eq("bp_hold_d", out_d, 64'hB000_0000_0000_0000);
    check_eq("bp_hold_radr", 64'(rx_radr), 64'h018);
    for (int i = 0; i < 4; i++) begin
      check_eq("bp_v", 64'(out_valid), 64'd1);
      check_eq("bp_d", out_d, 64'hB000_0000_0000_0000 + 64'(i));
      out_ready = 1'b1;
      @(negedge clk);
    end
    check_eq("bp_empty", 64'(out_valid), 64'd0);
    check_eq("bp_radr", 64'(rx_radr), 64'h038);

    // Fill up to the top of the buffer at full rate
    accepted = 0;
    bad = 0;
    gaps = 0;
    for (int a = 'h38; a <= 'hFF0; a += 8) begin
      wadr = 16'(a);
      wenb = 8'hFF;
      wdat = 64'hC0DE_0000_0000_0000 | 64'(a);
      @(negedge clk);
      sample_bulk();
    end
    wenb = 8'h00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sample_bulk();
    end
    check_eq("bulk_count", 64'(accepted), 64'd504);
    check_eq("bulk_bad", 64'(bad), 64'd0);
    check_eq("bulk_gaps", 64'(gaps), 64'd0);
    check_eq("bulk_radr", 64'(rx_radr), 64'hFF8);

    // Wrap
    wr(16'hFF8, 8'hFF, 64'hDEAD_BEEF_0000_0FF8);
    expect_word("wr0", 64'hDEAD_BEEF_0000_0FF8, 4'd8);
    @(negedge clk);
    check_eq("wr0_radr", 64'(rx_radr), 64'h000);
    wr(16'h000, 8'hFF, 64'hDEAD_BEEF_0000_0000);
    expect_word("wr1", 64'hDEAD_BEEF_0000_0000, 4'd8);
    @(negedge clk);
    check_eq("wr1_radr", 64'(rx_radr), 64'h008);

    // Clear handshake
    out_ready = 1'b0;
    wr(16'h008, 8'hFF, 64'h5555_AAAA_5555_AAAA);
    repeat (2) @(negedge clk);
    check_eq("clr_hold_v", 64'(out_valid), 64'd1);
    clr_enb = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (clr_req) pulses++;
    end
    check_eq("clr_blocked", 64'(pulses), 64'd0);
    out_ready = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (clr_req) pulses++;
    end
    check_eq("clr_pulse", 64'(pulses), 64'd1);
    check_eq("clr_radr", 64'(rx_radr), 64'd0);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (clr_req) pulses++;
    end
    check_eq("clr_no_repeat", 64'(pulses), 64'd0);
    clr_enb = 1'b0;
    repeat (2) @(negedge clk);
    clr_enb = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (clr_req) pulses++;
    end
    check_eq("clr_rearm", 64'(pulses), 64'd1);
    clr_enb = 1'b0;
    repeat (2) @(negedge clk);
    wr(16'h000, 8'hFF, 64'h0F0E_0D0C_0B0A_0908);
    expect_word("pc", 64'h0F0E_0D0C_0B0A_0908, 4'd8);
    @(negedge clk);
    check_eq("pc_radr", 64'(rx_radr), 64'h008);

    // Asynchronous reset mid-burst
    wr(16'h008, 8'hFF, 64'h1111_1111_1111_1111);
    wr(16'h010, 8'hFF, 64'h2222_2222_2222_2222);
    wr(16'h018, 8'hFF, 64'h3333_3333_3333_3333);
    @(negedge clk);
    check_eq("ar_pre_radr", 64'(rx_radr), 64'h010);
    check_eq("ar_pre_v", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_eq("ar_v", 64'(out_valid), 64'd0);
    check_eq("ar_radr", 64'(rx_radr), 64'd0);
    check_eq("ar_d", out_d, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr(16'h000, 8'hFF, 64'h7766_5544_3322_1100);
    expect_word("ar_post", 64'h7766_5544_3322_1100, 4'd8);
    @(negedge clk);
    check_eq("ar_post_radr", 64'(rx_radr), 64'h008);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
